gf_mul: RTL and testbench

//  GF(2^128) multiplier for the GHASH core of AES-GCM: oResult = iCtext * iHashkey.

---
 rtl/gf_mul.sv | 99 +++++++++
 tb/tb_gf_mul.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/gf_mul.sv
`default_nettype none
// ============================================================================
//  Module      : gf_mul
//  Description : GF(2^128) multiplier for the AES-GCM GHASH core.
//                oResult = iCtext * iHashkey modulo x^128 + x^7 + x^2 + x + 1,
//                GCM bit order (vector index i = coefficient of x^i, so index 0
//                is the MSB of a hex literal).
//                Two-stage pipeline, one product per clock:
//                  stage 1 registers the 255-bit carry-less product,
//                  stage 2 registers the reduced 128-bit remainder.
//  Ports       : iClk     - clock, all state on rising edge
//                iRst     - synchronous active-high reset, clears pipeline
//                iValid   - operands valid this cycle
//                iCtext   - operand X (accumulated block)
//                iHashkey - operand H (hash subkey)
//                oResult  - X*H, meaningful only while oValid is high
//                oValid   - oResult valid this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module gf_mul (
   input  logic         iClk,
   input  logic         iRst,
   input  logic         iValid,
   input  logic [0:127] iCtext,
   input  logic [0:127] iHashkey,
   output logic [0:127] oResult,
   output logic         oValid
);

   localparam int C_WIDTH  = 128;
   localparam int C_PWIDTH = 2 * C_WIDTH - 1;

   // Stage 1: raw carry-less product
   logic [0:C_PWIDTH-1] prod_d,   prod_q;
   logic                valid1_d, valid1_q;

   // Stage 2: reduced remainder
   logic [0:C_WIDTH-1]  res_d,    res_q;
   logic                valid2_d, valid2_q;

   // Working copy of the product while folding the high terms down
   logic [0:C_PWIDTH-1] red;

   // ------------------------------------------------------------------------
   // Stage 1: P = sum of H shifted up by i for every set X[i].
   // With an ascending range, prod_d[i +: C_WIDTH] places iHashkey[0] at
   // coefficient x^i, which is exactly the shift by x^i.
   // ------------------------------------------------------------------------
   always_comb begin
      prod_d   = '0;
      valid1_d = iValid;
      for (int i = 0; i < C_WIDTH; i++) begin
         prod_d[i +: C_WIDTH] = prod_d[i +: C_WIDTH] ^ (iHashkey & {C_WIDTH{iCtext[i]}});
      end
   end

   // ------------------------------------------------------------------------
   // Stage 2: fold each high coefficient x^k (k >= 128) using
   // x^128 == 1 + x + x^2 + x^7, i.e. x^k -> x^(k-128) + x^(k-127) +
   // x^(k-126) + x^(k-121). Walking k downwards guarantees that terms landing
   // at or above x^128 (from k >= 249) are folded again later in the loop.
   // ------------------------------------------------------------------------
   always_comb begin
      red      = prod_q;
      valid2_d = valid1_q;
      for (int k = C_PWIDTH - 1; k >= C_WIDTH; k--) begin
         if (red[k]) begin
            red[k]             = 1'b0;
            red[k - C_WIDTH]     = ~red[k - C_WIDTH];
            red[k - C_WIDTH + 1] = ~red[k - C_WIDTH + 1];
            red[k - C_WIDTH + 2] = ~red[k - C_WIDTH + 2];
            red[k - C_WIDTH + 7] = ~red[k - C_WIDTH + 7];
         end
      end
      res_d = red[0:C_WIDTH-1];
   end

   // ------------------------------------------------------------------------
   // Pipeline registers; reset discards any in-flight products.
   // ------------------------------------------------------------------------
   always_ff @(posedge iClk) begin
      if (iRst) begin
         prod_q   <= '0;
         valid1_q <= 1'b0;
         res_q    <= '0;
         valid2_q <= 1'b0;
      end else begin
         prod_q   <= prod_d;
         valid1_q <= valid1_d;
         res_q    <= res_d;
         valid2_q <= valid2_d;
      end
   end

   assign oResult = res_q;
   assign oValid  = valid2_q;

endmodule
`default_nettype wire

// File: tb/tb_gf_mul.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gf_mul
//  Description : Self-checking bench for gf_mul. Expected products come from
//                the bit-serial GCM multiply (shift-and-add with R = 0xe1..)
//                or from published constants; a queue of expected results
//                tagged with their due cycle tracks the 2-cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gf_mul;

   logic         clk;
   logic         rst;
   logic         valid_in;
   logic [0:127] ctext;
   logic [0:127] hkey;
   logic [0:127] result;
   logic         valid_out;

   gf_mul dut (
      .iClk     (clk),
      .iRst     (rst),
      .iValid   (valid_in),
      .iCtext   (ctext),
      .iHashkey (hkey),
      .oResult  (result),
      .oValid   (valid_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int           due;
      logic [127:0] data;
      string        tag;
   } exp_t;

   exp_t q[$];
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_fail = 0;

   localparam logic [127:0] C_R = 128'he1000000_00000000_00000000_00000000;

   // GCM multiply, bit-serial: walk X from x^0 upward, multiplying V by x
   // (plain right shift of the hex value, fold with R on overflow).
   function automatic logic [127:0] gmul(input logic [127:0] x, input logic [127:0] y);
      logic [127:0] z;
      logic [127:0] v;
      z = '0;
      v = y;
      for (int i = 0; i < 128; i++) begin
         if (x[127 - i]) z = z ^ v;
         if (v[0]) v = (v >> 1) ^ C_R;
         else      v = v >> 1;
      end
      return z;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Advance one clock and check whatever is due on this edge.
   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
      if (q.size() > 0 && q[0].due == cyc) begin
         chk({q[0].tag, "_valid"}, {127'b0, valid_out}, 128'd1);
         chk(q[0].tag, result, q[0].data);
         void'(q.pop_front());
      end else begin
         chk("idle_valid", {127'b0, valid_out}, 128'd0);
      end
   endtask

   task automatic drive(input logic v, input logic [127:0] x, input logic [127:0] h,
                        input logic [127:0] exp, input string tag);
      exp_t e;
      valid_in = v;
      ctext    = x;
      hkey     = h;
      if (v) begin
         e.due  = cyc + 2;
         e.data = exp;
         e.tag  = tag;
         q.push_back(e);
      end
      tick();
   endtask

   task automatic idle(input int n);
      valid_in = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic reset_edge(input string tag);
      q.delete();
      rst = 1'b1;
      @(posedge clk);
      cyc++;
      #1;
      chk({tag, "_valid"}, {127'b0, valid_out}, 128'd0);
      chk({tag, "_result"}, result, 128'd0);
   endtask

   localparam logic [127:0] C_X1 = 128'hfeedfacedeadbeeffeedfacedeadbeef;
   localparam logic [127:0] C_H1 = 128'h80000000000000000000000000000000;
   localparam logic [127:0] C_X2 = 128'h00000000000000000000000000000001;
   localparam logic [127:0] C_H2 = 128'h40000000000000000000000000000000;
   localparam logic [127:0] C_E2 = 128'he1000000000000000000000000000000;
   localparam logic [127:0] C_X3 = 128'h0388dace60b6a392f328c2b971b2fe78;
   localparam logic [127:0] C_H3 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
   localparam logic [127:0] C_E3 = 128'h5e2ec746917062882c85b0685353deb7;
   localparam logic [127:0] C_H4 = 128'h466923ec9ae682214f2c082badb39249;

   initial begin
      logic [127:0] rx;
      logic [127:0] rh;
      logic         rv;

      rst      = 1'b1;
      valid_in = 1'b0;
      ctext    = '0;
      hkey     = '0;

      // Reset state
      reset_edge("reset");
      reset_edge("reset2");
      rst = 1'b0;
      idle(2);

      // Directed cases, each isolated by idle cycles
      drive(1'b1, C_X1, C_H1, C_X1, "mul_one");
      idle(3);
      drive(1'b1, C_X2, C_H2, C_E2, "mul_x_wrap");
      idle(3);
      drive(1'b1, C_X3, C_H3, C_E3, "gcm_tc2");
      idle(3);
      drive(1'b1, C_X1, C_H4, gmul(C_X1, C_H4), "case4_xh");
      drive(1'b1, C_H4, C_X1, gmul(C_X1, C_H4), "case4_hx");
      idle(3);

      // Back-to-back cases 1-4
      drive(1'b1, C_X1, C_H1, C_X1, "b2b_1");
      drive(1'b1, C_X2, C_H2, C_E2, "b2b_2");
      drive(1'b1, C_X3, C_H3, C_E3, "b2b_3");
      drive(1'b1, C_X1, C_H4, gmul(C_X1, C_H4), "b2b_4");
      idle(3);

      // Zero operands
      drive(1'b1, C_X3, 128'd0, 128'd0, "h_zero");
      drive(1'b1, 128'd0, C_H3, 128'd0, "x_zero");
      idle(3);

      // Reset with two products in flight: one in stage 1, one at the input
      drive(1'b1, C_X3, C_H3, C_E3, "inflight_a");
      valid_in = 1'b1;
      ctext    = C_X1;
      hkey     = C_H4;
      reset_edge("rst_flush");
      rst      = 1'b0;
      valid_in = 1'b0;
      idle(4);

      // Random pairs, occasionally with iValid low
      for (int n = 0; n < 10000; n++) begin
         rx = {$urandom, $urandom, $urandom, $urandom};
         rh = {$urandom, $urandom, $urandom, $urandom};
         rv = ($urandom_range(0, 3) != 0);
         drive(rv, rx, rh, gmul(rx, rh), "random");
      end
      idle(4);

      n_chk++;
      assert (q.size() == 0)
      else begin
         n_fail++;
         $error("FAIL drain: got %0d pending want 0", q.size());
      end

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

   // Hard bound on simulated time
   initial begin
      #2000000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
